// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes,
// controller state encoding and op classification helpers.
package hilo_muldiv_ctrl_pkg;

  localparam logic [7:0] INST_MTHI  = 8'h11;
  localparam logic [7:0] INST_MTLO  = 8'h13;
  localparam logic [7:0] INST_MULT  = 8'h18;
  localparam logic [7:0] INST_MULTU = 8'h19;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;
  localparam logic [7:0] INST_MADD  = 8'h40;
  localparam logic [7:0] INST_MADDU = 8'h41;
  localparam logic [7:0] INST_MSUB  = 8'h44;
  localparam logic [7:0] INST_MSUBU = 8'h45;

  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_MUL  = 2'd1;
  localparam logic [1:0] MD_ST_DIV  = 2'd2;
  localparam logic [1:0] MD_ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = MD_ST_IDLE,
    S_MUL  = MD_ST_MUL,
    S_DIV  = MD_ST_DIV,
    S_DONE = MD_ST_DONE
  } md_state_t;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == INST_DIV) || (op == INST_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == INST_MULT) || (op == INST_MULTU) ||
           (op == INST_MADD) || (op == INST_MADDU) ||
           (op == INST_MSUB) || (op == INST_MSUBU);
  endfunction

  function automatic logic is_multi_op(input logic [7:0] op);
    return is_div_op(op) || is_mul_op(op);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == INST_MULT) || (op == INST_DIV) ||
           (op == INST_MADD) || (op == INST_MSUB);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring unsigned divider: one quotient bit per cycle after start.
// done is high during the cycle whose clock edge retires the last step.
module div_iter #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [32:0]      partial;
  logic [32:0]      diff;

  assign partial = {rem_q, quot_q[31]};
  assign diff    = partial - {1'b0, dvs_q};
  assign done    = run_q && (cnt_q == CNT_W'(DIV_CYCLES - 1));
  assign quot    = quot_q;
  assign rem     = rem_q;

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      quot_d = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (run_q) begin
      // Keep the shifted partial remainder only when the trial subtract underflows.
      if (!diff[32]) begin
        rem_d  = diff[31:0];
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = partial[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer beside EX: owns HI/LO, runs MULT/DIV/MADD/MSUB
// families over several cycles and stalls the pipeline while they run.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  op,
  input  logic        op_valid,
  input  logic        flush,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  md_state_t   state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        accept_multi;
  logic        div_start;
  logic [31:0] dvd_mag, dvs_mag;
  logic [31:0] div_quot, div_rem;
  logic        div_done;
  logic        neg_a, neg_b;
  logic [31:0] quot_fix, rem_fix;
  logic signed [32:0] mul_a, mul_b;

  assign accept_multi = (state_q == S_IDLE) && op_valid && is_multi_op(op) && !flush;
  assign div_start    = accept_multi && is_div_op(op) && (opb != 32'd0);

  // The divider sees magnitudes straight from the operand bus on the accept edge.
  assign dvd_mag = (is_signed_op(op) && opa[31]) ? (~opa + 32'd1) : opa;
  assign dvs_mag = (is_signed_op(op) && opb[31]) ? (~opb + 32'd1) : opb;

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  assign neg_a    = is_signed_op(op_q) && opa_q[31];
  assign neg_b    = is_signed_op(op_q) && opb_q[31];
  assign quot_fix = (neg_a ^ neg_b) ? (~div_quot + 32'd1) : div_quot;
  assign rem_fix  = neg_a ? (~div_rem + 32'd1) : div_rem;

  assign mul_a = {is_signed_op(op_q) && opa_q[31], opa_q};
  assign mul_b = {is_signed_op(op_q) && opb_q[31], opb_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (is_multi_op(op)) begin
            op_d  = op;
            opa_d = opa;
            opb_d = opb;
            if (is_div_op(op)) state_d = (opb == 32'd0) ? S_DONE : S_DIV;
            else               state_d = S_MUL;
          end else if (op == INST_MTHI) begin
            hi_d = opa;
          end else if (op == INST_MTLO) begin
            lo_d = opa;
          end
        end
      end
      S_MUL: begin
        prod_d  = 64'(mul_a * mul_b);
        state_d = S_DONE;
      end
      S_DIV: begin
        if (div_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        case (op_q)
          INST_MULT, INST_MULTU: {hi_d, lo_d} = prod_q;
          INST_MADD, INST_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
          INST_MSUB, INST_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
          INST_DIV, INST_DIVU: begin
            // A zero divisor skipped the divider entirely; HI/LO stay as they were.
            if (opb_q != 32'd0) begin
              lo_d = quot_fix;
              hi_d = rem_fix;
            end
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign stall = accept_multi || (state_q == S_MUL) || (state_q == S_DIV);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized bench for hilo_muldiv_ctrl against an arithmetic HI/LO model,
// with directed cases for divide-by-zero, overflow, flush and mid-op reset.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MUL2 = 8'h42;
  localparam logic [7:0] OP_JUNK = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  op;
  logic        op_valid;
  logic        flush;
  logic [31:0] opa, opb;
  logic        stall;
  logic [31:0] hi, lo;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  hilo_muldiv_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .op_valid (op_valid),
    .flush    (flush),
    .opa      (opa),
    .opb      (opb),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic model_apply(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                             output int exp_stall);
    logic [63:0] acc, p_s, p_u;
    longint sa, sb, q, r;
    acc = {hi_m, lo_m};
    p_s = longint'($signed(a)) * longint'($signed(b));
    p_u = {32'd0, a} * {32'd0, b};
    exp_stall = 0;
    case (o)
      INST_MULT:  begin acc = p_s;       exp_stall = 2; end
      INST_MULTU: begin acc = p_u;       exp_stall = 2; end
      INST_MADD:  begin acc = acc + p_s; exp_stall = 2; end
      INST_MADDU: begin acc = acc + p_u; exp_stall = 2; end
      INST_MSUB:  begin acc = acc - p_s; exp_stall = 2; end
      INST_MSUBU: begin acc = acc - p_u; exp_stall = 2; end
      INST_DIV: begin
        if (b == 32'd0) exp_stall = 1;
        else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          acc = {r[31:0], q[31:0]};
          exp_stall = 33;
        end
      end
      INST_DIVU: begin
        if (b == 32'd0) exp_stall = 1;
        else begin
          acc = {a % b, a / b};
          exp_stall = 33;
        end
      end
      INST_MTHI: acc[63:32] = a;
      INST_MTLO: acc[31:0]  = a;
      default: ;
    endcase
    {hi_m, lo_m} = acc;
    exp_q.push_back(acc);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; holds the instruction until stall drops,
  // then lets it advance through one more edge, like the EX stage would.
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n, exp_n;
    logic busy_at;
    logic [63:0] e;
    model_apply(o, a, b, exp_n);
    op = o; opa = a; opb = b; op_valid = 1'b1;
    n = 0;
    busy_at = 1'b0;
    forever begin
      @(negedge clk);
      if (!stall) begin
        busy_at = busy;
        break;
      end
      n++;
      if (n > 100) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    check_eq($sformatf("%s stall_cycles", tag), 64'(n), 64'(exp_n));
    check_eq($sformatf("%s busy_in_done", tag), 64'(busy_at), 64'(exp_n != 0));
    e = exp_q.pop_front();
    check_eq($sformatf("%s hilo", tag), {hi, lo}, e);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] edges [4];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($urandom_range(0, 20));
      2:       return -32'($urandom_range(1, 20));
      default: return edges[$urandom_range(0, 3)];
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0] op_tbl [14];

  initial begin
    logic [63:0] held;
    op_tbl = '{INST_MULT, INST_MULTU, INST_DIV, INST_DIVU, INST_MADD, INST_MADDU,
               INST_MSUB, INST_MSUBU, INST_MTHI, INST_MTLO, OP_MFHI, OP_MFLO,
               OP_MUL2, OP_JUNK};
    rst_n = 1'b0; op = '0; op_valid = 1'b0; flush = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset hilo", {hi, lo}, 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op(INST_MULT,  32'hFFFF_FFFF, 32'h2, "mult_neg1x2");
    run_op(INST_MULTU, 32'hFFFF_FFFF, 32'h2, "multu_max_x2");
    run_op(INST_DIV,   -32'd7, 32'd2, "div_m7_2");
    run_op(INST_DIVU,  32'd7, 32'd0, "divu_by_zero");
    run_op(INST_MTHI,  32'h1, 32'h0, "mthi");
    run_op(INST_MTLO,  32'h0, 32'h0, "mtlo");
    run_op(INST_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu_wrap");
    run_op(INST_MTHI,  32'h0, 32'h0, "mthi0");
    run_op(INST_MTLO,  32'h0, 32'h0, "mtlo0");
    run_op(INST_MSUB,  32'h1, 32'h1, "msub_underflow");
    run_op(INST_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(INST_DIV,   32'd7, 32'd0, "div_by_zero");
    run_op(OP_MUL2,    32'd5, 32'd6, "special2_mul_ignored");

    // a multi-cycle op on the bus without op_valid must do nothing
    op = INST_DIV; opa = 32'd100; opb = 32'd3; op_valid = 1'b0;
    @(negedge clk);
    check_eq("no_valid stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("no_valid busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // flush in the tenth DIV cycle
    run_op(INST_MTHI, 32'hAAAA_5555, 32'h0, "pre_flush_hi");
    run_op(INST_MTLO, 32'h1234_5678, 32'h0, "pre_flush_lo");
    held = {hi_m, lo_m};
    op = INST_DIV; opa = 32'd1000; opb = 32'd7; op_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("div_flush stall", 64'(stall), 64'd0);
    check_eq("div_flush busy", 64'(busy), 64'd0);
    check_eq("div_flush hilo", {hi, lo}, held);
    repeat (30) @(posedge clk);
    #1;
    check_eq("div_flush hilo_later", {hi, lo}, held);

    // flush in DONE discards the product
    op = INST_MULT; opa = 32'd9; opb = 32'd9; op_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check_eq("done_flush hilo", {hi, lo}, held);
    check_eq("done_flush busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // asynchronous reset while in MUL
    op = INST_MULT; opa = 32'd5; opb = 32'd6; op_valid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; op_valid = 1'b0;
    #1;
    check_eq("midreset hilo", {hi, lo}, 64'd0);
    check_eq("midreset busy", 64'(busy), 64'd0);
    check_eq("midreset stall", 64'(stall), 64'd0);
    hi_m = '0; lo_m = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(INST_MULT, 32'd3, 32'd4, "mult_after_reset");

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      run_op(op_tbl[$urandom_range(0, 13)], rand_operand(), rand_operand(),
             $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
